// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Uses the same 5-bit function encoding as the older combinational ALU.
// MUL is either a WIDTH-cycle shift-add (MUL_SEQ=1) or single-cycle (MUL_SEQ=0).
// Results, flags and out_valid are all registered.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter bit MUL_SEQ = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             zero,
    output logic             neg,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_SHL  = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_BAND = 5'b00101;
    localparam logic [4:0] OP_BOR  = 5'b00110;
    localparam logic [4:0] OP_BXOR = 5'b00111;
    localparam logic [4:0] OP_AND  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_EQ   = 5'b01010;
    localparam logic [4:0] OP_NE   = 5'b01011;
    localparam logic [4:0] OP_GE   = 5'b01100;
    localparam logic [4:0] OP_LE   = 5'b01101;
    localparam logic [4:0] OP_GT   = 5'b01110;
    localparam logic [4:0] OP_LT   = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_BNOT = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] mul_a_r;
    logic [WIDTH-1:0] mul_b_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;

    logic             accept_s;
    logic             seq_mul_s;
    logic [WIDTH:0]   eval_s;
    logic [WIDTH-1:0] step_acc_s;

    // Zero-extend a truth value to a full result word.
    function automatic logic [WIDTH-1:0] to_word(input logic x);
        return {{(WIDTH-1){1'b0}}, x};
    endfunction

    // Single-cycle evaluation of every function code; returns {err, result}.
    function automatic logic [WIDTH:0] alu_eval(input logic [WIDTH-1:0] op_a,
                                                 input logic [WIDTH-1:0] op_b,
                                                 input logic [4:0]       op_f);
        logic [WIDTH-1:0]        res;
        logic signed [WIDTH-1:0] sra;
        logic                    bad;
        logic                    big_shift;
        res       = '0;
        bad       = 1'b0;
        big_shift = (op_b >= SHIFT_LIM);
        // kept in a signed variable so the shift stays arithmetic
        sra       = $signed(op_a) >>> op_b;
        case (op_f)
            OP_ADD:  res = op_a + op_b;
            OP_SUB:  res = op_a - op_b;
            OP_MUL:  res = op_a * op_b;
            OP_SHL:  res = big_shift ? '0 : (op_a << op_b);
            OP_SHR:  res = big_shift ? {WIDTH{op_a[WIDTH-1]}} : sra;
            OP_BAND: res = op_a & op_b;
            OP_BOR:  res = op_a | op_b;
            OP_BXOR: res = op_a ^ op_b;
            OP_AND:  res = to_word((op_a != '0) && (op_b != '0));
            OP_OR:   res = to_word((op_a != '0) || (op_b != '0));
            OP_EQ:   res = to_word(op_a == op_b);
            OP_NE:   res = to_word(op_a != op_b);
            OP_GE:   res = to_word($signed(op_a) >= $signed(op_b));
            OP_LE:   res = to_word($signed(op_a) <= $signed(op_b));
            OP_GT:   res = to_word($signed(op_a) >  $signed(op_b));
            OP_LT:   res = to_word($signed(op_a) <  $signed(op_b));
            OP_NEG:  res = '0 - op_a;
            OP_BNOT: res = ~op_a;
            OP_NOT:  res = to_word(op_a == '0);
            default: begin
                res = '0;
                bad = 1'b1;
            end
        endcase
        return {bad, res};
    endfunction

    // Input readiness depends only on state and downstream readiness.
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_MUL:  in_ready = 1'b0;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Handshake decode, single-cycle result and next shift-add partial sum.
    always_comb begin
        accept_s   = in_valid && in_ready;
        seq_mul_s  = MUL_SEQ && (f == OP_MUL);
        eval_s     = alu_eval(a, b, f);
        step_acc_s = acc_r + (mul_b_r[0] ? mul_a_r : '0);
    end

    // Control FSM with the registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            out_valid <= 1'b0;
            s         <= '0;
            zero      <= 1'b1;
            neg       <= 1'b0;
            err       <= 1'b0;
            mul_a_r   <= '0;
            mul_b_r   <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (seq_mul_s) begin
                            // operands captured here; later input changes are ignored
                            mul_a_r   <= a;
                            mul_b_r   <= b;
                            acc_r     <= '0;
                            cnt_r     <= '0;
                            out_valid <= 1'b0;
                            state_r   <= ST_MUL;
                        end else begin
                            s         <= eval_s[WIDTH-1:0];
                            zero      <= (eval_s[WIDTH-1:0] == '0);
                            neg       <= eval_s[WIDTH-1];
                            err       <= eval_s[WIDTH];
                            out_valid <= 1'b1;
                            state_r   <= ST_DONE;
                        end
                    end else if ((state_r == ST_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_r   <= step_acc_s;
                    mul_a_r <= mul_a_r << 1;
                    mul_b_r <= mul_b_r >> 1;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        s         <= step_acc_s;
                        zero      <= (step_acc_s == '0);
                        neg       <= step_acc_s[WIDTH-1];
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= ST_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a
// transaction-level reference model kept in this bench.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]   f = 5'd0;
    logic         in_ready, out_valid, zero, neg, err;
    logic [W-1:0] s;

    logic         in_valid0 = 1'b0;
    logic         in_ready0, out_valid0, zero0, neg0, err0;
    logic [W-1:0] s0;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    bit rnd = 1'b0;

    // model state
    bit           m_valid = 1'b0;
    logic [W-1:0] m_s = '0;
    bit           m_err = 1'b0;
    int           mul_left = 0;
    logic [W-1:0] mul_res = '0;
    int           acc_cnt = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_SEQ(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .f(f), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .zero(zero), .neg(neg), .err(err)
    );

    alu_seq #(.WIDTH(W), .MUL_SEQ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a), .b(b), .f(f), .out_valid(out_valid0), .out_ready(1'b1),
        .s(s0), .zero(zero0), .neg(neg0), .err(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer arithmetic, returns {err, result}.
    function automatic logic [W:0] ref_alu(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, r;
        bit e;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = 0;
        e = 1'b0;
        case (op)
            5'd0:  r = sx + sy;
            5'd1:  r = sx - sy;
            5'd2:  r = sx * sy;
            5'd3:  r = (y >= W) ? 64'sd0 : (sx << y);
            5'd4:  r = (y >= W) ? ((sx < 0) ? -64'sd1 : 64'sd0) : (sx >>> y);
            5'd5:  r = sx & sy;
            5'd6:  r = sx | sy;
            5'd7:  r = sx ^ sy;
            5'd8:  r = (sx != 0 && sy != 0) ? 1 : 0;
            5'd9:  r = (sx != 0 || sy != 0) ? 1 : 0;
            5'd10: r = (sx == sy) ? 1 : 0;
            5'd11: r = (sx != sy) ? 1 : 0;
            5'd12: r = (sx >= sy) ? 1 : 0;
            5'd13: r = (sx <= sy) ? 1 : 0;
            5'd14: r = (sx > sy) ? 1 : 0;
            5'd15: r = (sx < sy) ? 1 : 0;
            5'd16: r = -sx;
            5'd17: r = ~sx;
            5'd18: r = (sx == 0) ? 1 : 0;
            default: e = 1'b1;
        endcase
        return {e, r[W-1:0]};
    endfunction

    // Transaction-level model: a MUL is a countdown of W cycles, anything else lands next cycle.
    always @(posedge clk) begin
        bit rdy;
        logic [W:0] r;
        if (rst) begin
            m_valid = 1'b0; m_s = '0; m_err = 1'b0; mul_left = 0;
        end else begin
            rdy = (mul_left == 0) && (!m_valid || out_ready);
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    m_valid = 1'b1; m_s = mul_res; m_err = 1'b0;
                end
            end else begin
                if (m_valid && out_ready) m_valid = 1'b0;
                if (in_valid && rdy) begin
                    acc_cnt++;
                    r = ref_alu(f, a, b);
                    if (f == 5'd2) begin
                        mul_left = W; mul_res = r[W-1:0];
                    end else begin
                        m_valid = 1'b1; m_s = r[W-1:0]; m_err = r[W];
                    end
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the clock edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", in_ready, ((mul_left == 0) && (!m_valid || out_ready)) ? 1 : 0);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("s", s, m_s);
                chk("zero", zero, (m_s == '0) ? 1 : 0);
                chk("neg", neg, m_s[W-1]);
                chk("err", err, m_err);
            end
        end
    end

    task automatic send(input logic [4:0] ff, input logic [W-1:0] aa, input logic [W-1:0] bb);
        int start, n;
        f = ff; a = aa; b = bb; in_valid = 1'b1;
        start = acc_cnt; n = 0;
        while (acc_cnt == start && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        chk("accepted", acc_cnt - start, 1);
    endtask

    logic [W-1:0] av, bv;
    logic [4:0]   cmp_ops [9];
    logic [W-1:0] cmp_exp [9];
    int k;

    initial begin
        av = 16'hFFFD;   // -3
        bv = 16'd1475;

        // pin the model with hand-computed values
        chk("pin_add",  ref_alu(5'd0,  av, bv), {1'b0, 16'd1472});
        chk("pin_sub",  ref_alu(5'd1,  av, bv), {1'b0, 16'hFA3A});
        chk("pin_mul",  ref_alu(5'd2,  av, bv), {1'b0, 16'hEEB7});
        chk("pin_shl",  ref_alu(5'd3,  av, bv), {1'b0, 16'h0000});
        chk("pin_shr",  ref_alu(5'd4,  av, bv), {1'b0, 16'hFFFF});
        chk("pin_shr4", ref_alu(5'd4,  16'h8010, 16'd4), {1'b0, 16'hF801});
        chk("pin_ge",   ref_alu(5'd12, av, bv), {1'b0, 16'd0});
        chk("pin_lt",   ref_alu(5'd15, av, bv), {1'b0, 16'd1});
        chk("pin_und",  ref_alu(5'd19, av, bv), {1'b1, 16'd0});
        chk("pin_bxor", ref_alu(5'd7,  16'h00F0, 16'h0FF0), {1'b0, 16'h0F00});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_zero", zero, 1);
        chk("rst_neg", neg, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // back-to-back single-cycle ops
        out_ready = 1'b1;
        send(5'd0, av, bv); chk("t1_add", s, 16'd1472);  chk("t1_add_neg", neg, 0);
        send(5'd1, av, bv); chk("t1_sub", s, 16'hFA3A);  chk("t1_sub_neg", neg, 1);
        send(5'd3, av, bv); chk("t1_shl", s, 16'h0000);  chk("t1_shl_neg", neg, 0);
        send(5'd4, av, bv); chk("t1_shr", s, 16'hFFFF);  chk("t1_shr_neg", neg, 1);
        chk("t1_in_ready", in_ready, 1);

        // sequential MUL latency
        send(5'd2, av, bv);
        chk("mul_first_valid", out_valid, 0);
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) break;
        end
        chk("mul_latency", k, 16);
        chk("mul_s", s, 16'hEEB7);
        chk("mul_neg", neg, 1);

        // single-cycle MUL variant
        @(posedge clk); #1;
        f = 5'd2; a = av; b = bv; in_valid0 = 1'b1;
        chk("mul0_in_ready", in_ready0, 1);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        chk("mul0_valid", out_valid0, 1);
        chk("mul0_s", s0, 16'hEEB7);
        chk("mul0_flags", {zero0, neg0, err0}, 3'b010);

        // logical and comparison ops
        cmp_ops = '{5'd18, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd8, 5'd9};
        cmp_exp = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd1, 16'd1};
        for (int i = 0; i < 9; i++) begin
            send(cmp_ops[i], av, bv);
            chk("t3_s", s, cmp_exp[i]);
            chk("t3_zero", zero, (cmp_exp[i] == 16'd0) ? 1 : 0);
        end

        // backpressure with a pending new op
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(5'd0, av, bv);
        f = 5'd1; in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_hold_s", s, 16'd1472);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_follow", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_new_s", s, 16'hFA3A);
        chk("bp_new_valid", out_valid, 1);

        // reset in the middle of a MUL
        @(posedge clk); #1;
        send(5'd2, av, bv);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_s", s, 0);
        chk("mrst_zero", zero, 1);
        chk("mrst_in_ready", in_ready, 1);
        repeat (25) @(posedge clk);
        #1;
        chk("mrst_no_result", out_valid, 0);
        send(5'd0, av, bv);
        chk("mrst_add", s, 16'd1472);

        // undefined code then BXOR
        send(5'd19, av, bv);
        chk("und_s", s, 0);
        chk("und_err", err, 1);
        chk("und_zero", zero, 1);
        send(5'd7, 16'h00F0, 16'h0FF0);
        chk("bxor_s", s, 16'h0F00);
        chk("bxor_err", err, 0);

        // randomized traffic with random backpressure
        rnd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [4:0]   rf;
            logic [W-1:0] ra, rb;
            rf = ($urandom_range(0, 5) == 0) ? 5'd2 : 5'($urandom_range(0, 31));
            ra = W'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            send(rf, ra, rb);
            a = W'($urandom); b = W'($urandom); f = 5'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the team's 16-bit combinational ALU. It keeps the same 5-bit function encoding and adds a configurable datapath width and valid/ready handshakes on both sides. It provides a multi-cycle shift-add multiplier, status flags and an error flag for undefined codes. It sits between the operand-fetch stage and the result-writeback stage of the datapath.

Parameters:
WIDTH, 16, operand/result width in bits (>=4).
MUL_SEQ, 1, 1 = MUL is a sequential shift-add taking WIDTH cycles; 0 = MUL is single-cycle like the other ops.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operand/opcode present.
in_ready  output  1  block can accept; transfer when in_valid && in_ready.
a  input  WIDTH  signed operand A.
b  input  WIDTH  signed operand B (unsigned shift amount for SHL/SHR).
f  input  5  function code.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
s  output  WIDTH  signed result, registered.
zero  output  1  s == 0, registered with s.
neg  output  1  s[WIDTH-1], registered with s.
err  output  1  result came from an undefined f.

Behaviour:
- Function codes: ADD 00000, SUB 00001, MUL 00010, SHL 00011, SHR 00100, BAND 00101, BOR 00110, BXOR 00111, AND 01000, OR 01001, EQ 01010, NE 01011, GE 01100, LE 01101, GT 01110, LT 01111, NEG 10000, BNOT 10001, NOT 10010.
- Undefined codes 10011..11111: s=0, err=1. All defined codes give err=0.
- Arithmetic is two's complement, truncated to WIDTH bits, with no overflow flag. MUL returns the low WIDTH bits of a*b.
- SHL is a logical left shift. SHR is an arithmetic right shift. b is treated as unsigned. If b >= WIDTH, SHL gives 0 and SHR gives WIDTH copies of a's sign bit.
- NOT, AND, OR, EQ..LT return 1 or 0, zero-extended. Comparisons are signed. AND/OR treat any nonzero operand as true.
- States: IDLE, MUL, DONE.
- IDLE: in_ready=1. On accept of a non-MUL op (or MUL when MUL_SEQ=0), compute, load s/zero/neg/err, and go to DONE. out_valid is high the cycle after accept (latency 1).
- IDLE, MUL with MUL_SEQ=1: on accept, latch a, b and clear the accumulator and counter. Go to MUL. in_ready=0.
- MUL: one shift-add step per cycle; the counter runs 0..WIDTH-1. On the step with counter == WIDTH-1, load the result and go to DONE. out_valid rises exactly WIDTH cycles after the accept edge. in_valid is ignored while in this state.
- DONE: out_valid=1. s/zero/neg/err stay stable until the output transfer. in_ready = out_ready.
  - out_ready=0: hold.
  - out_ready=1 with no new input: go to IDLE; out_valid drops next cycle.
  - out_ready=1 with in_valid (simultaneous): retire the current result and accept the new op in the same edge. A non-MUL op stays in DONE with the new result, giving one result per cycle with no bubble. A MUL op goes to MUL.
- in_ready is a combinational function of state and out_ready only. It never depends on in_valid.
- Reset (any state, including mid-MUL): state=IDLE, out_valid=0, s=0, zero=1, neg=0, err=0, counter/accumulator=0.
  - An in-flight MUL is discarded with no result.
  - Inputs are ignored on any cycle where rst=1.
- Inputs a/b/f are sampled only on the accept edge. Changes afterwards do not affect an in-flight MUL.

Test Plan:
1. WIDTH=16, a=-3, b=1475, issue ADD, SUB, SHL, SHR back-to-back with out_ready=1 -> s=1472, -1478, 0, -1 (0xFFFF) on consecutive cycles; in_ready stays 1; neg=0,1,0,1.
2. Same operands, MUL_SEQ=1, MUL -> in_ready=0 for 16 cycles; out_valid exactly 16 cycles after accept; s=-4425 (0xEEB7), neg=1. With MUL_SEQ=0 -> same value at latency 1.
3. a=-3, b=1475: NOT, EQ, NE, GE, LE, GT, LT, AND, OR -> s=0, 0, 1, 0, 1, 0, 1, 1, 1; zero flag tracks s.
4. Backpressure: after the ADD result is valid, hold out_ready=0 for 5 cycles while in_valid=1 with a new op -> s holds 1472, in_ready=0, no input accepted; raising out_ready transfers 1472 and accepts the new op on the same edge.
5. Assert rst for 1 cycle in MUL cycle 7 -> next cycle state IDLE, out_valid=0, s=0, zero=1; no MUL result ever appears; the next ADD works normally.
6. f=10011 -> s=0, err=1, zero=1; the following BXOR with a=0x00F0, b=0x0FF0 -> s=0x0F00, err=0.
